// File: rtl/bot_feeder_if.sv
// Pull-side bundle between the bot feeder and its producer/consumer: the write port, the
// graph-request port, result return and status.
interface bot_feeder_if #(
    parameter int unsigned EXTRA_DATA_WIDTH  = 14,
    parameter int unsigned DEPTH_LOG2        = 4,
    parameter int unsigned OUTSTANDING_WIDTH = 6
);
    logic                          writeValid;
    logic [127:0]                  writeBot;
    logic [EXTRA_DATA_WIDTH-1:0]   writeExtra;
    logic                          writeReady;
    logic                          requestGraph;
    logic [127:0]                  botOut;
    logic [EXTRA_DATA_WIDTH-1:0]   extraDataOut;
    logic                          graphAvailable;
    logic                          resultDone;
    logic [OUTSTANDING_WIDTH-1:0]  outstanding;
    logic [DEPTH_LOG2:0]           fifoCount;
    logic                          idle;
    logic                          underflowError;

    modport master (
        output writeValid, writeBot, writeExtra, requestGraph, resultDone,
        input  writeReady, botOut, extraDataOut, graphAvailable, outstanding,
               fifoCount, idle, underflowError
    );

    modport slave (
        input  writeValid, writeBot, writeExtra, requestGraph, resultDone,
        output writeReady, botOut, extraDataOut, graphAvailable, outstanding,
               fifoCount, idle, underflowError
    );
endinterface

// File: rtl/bot_feeder.sv
// FWFT work-item FIFO feeding the compute module's graph-request port, with in-flight
// accounting, an issue ceiling and an idle flag for job completion.
module bot_feeder #(
    parameter int unsigned EXTRA_DATA_WIDTH  = 14,
    parameter int unsigned DEPTH_LOG2        = 4,
    parameter int unsigned OUTSTANDING_WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    bot_feeder_if.slave      bus
);
    localparam int unsigned BOT_WIDTH = 128;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_WIDTH = DEPTH_LOG2 + 1;
    localparam int unsigned OUT_MAX   = (1 << OUTSTANDING_WIDTH) - 1;

    logic [DEPTH_LOG2-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;
    logic [OUTSTANDING_WIDTH-1:0] outst_q, outst_d;
    logic                         underflow_q, underflow_d;

    logic [BOT_WIDTH-1:0]         bot_mem_q   [DEPTH];
    logic [EXTRA_DATA_WIDTH-1:0]  extra_mem_q [DEPTH];

    logic full, empty, at_ceiling, push, pop;

    // Status is derived from registers only; requests never reach an output combinationally.
    assign full       = (count_q == CNT_WIDTH'(DEPTH));
    assign empty      = (count_q == '0);
    assign at_ceiling = (outst_q == OUTSTANDING_WIDTH'(OUT_MAX));
    assign push       = bus.writeValid & ~full;
    assign pop        = bus.requestGraph & ~empty & ~at_ceiling;

    assign bus.writeReady     = ~full;
    assign bus.graphAvailable = ~empty & ~at_ceiling;
    assign bus.botOut         = bot_mem_q[rd_ptr_q];
    assign bus.extraDataOut   = extra_mem_q[rd_ptr_q];
    assign bus.outstanding    = outst_q;
    assign bus.fifoCount      = count_q;
    assign bus.idle           = empty & (outst_q == '0);
    assign bus.underflowError = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        outst_d     = outst_q;
        underflow_d = underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

        if (push && !pop)      count_d = count_q + CNT_WIDTH'(1);
        else if (!push && pop) count_d = count_q - CNT_WIDTH'(1);

        // A return in the same cycle as an issue cancels out.
        if (pop && !bus.resultDone) begin
            outst_d = outst_q + OUTSTANDING_WIDTH'(1);
        end else if (!pop && bus.resultDone) begin
            if (outst_q != '0) outst_d = outst_q - OUTSTANDING_WIDTH'(1);
            else               underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            bot_mem_q[wr_ptr_q]   <= bus.writeBot;
            extra_mem_q[wr_ptr_q] <= bus.writeExtra;
        end
    end
endmodule

// File: tb/tb_bot_feeder.sv
// Directed bench for bot_feeder: FIFO ordering/full handling, issue accounting, ceiling,
// underflow and asynchronous reset.
module tb_bot_feeder;
    localparam int unsigned EW = 14;
    localparam int unsigned DL = 4;
    localparam int unsigned OW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bot_feeder_if #(.EXTRA_DATA_WIDTH(EW), .DEPTH_LOG2(DL), .OUTSTANDING_WIDTH(OW)) bus ();

    bot_feeder #(.EXTRA_DATA_WIDTH(EW), .DEPTH_LOG2(DL), .OUTSTANDING_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.writeValid   = 1'b0;
        bus.writeBot     = '0;
        bus.writeExtra   = '0;
        bus.requestGraph = 1'b0;
        bus.resultDone   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_write(input logic v, input int tag);
        bus.writeValid = v;
        bus.writeExtra = EW'(tag);
        bus.writeBot   = 128'(tag) + 128'd1000;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.writeReady !== 1'b1) begin n_fail++; $display("FAIL reset_writeReady got %b exp 1", bus.writeReady); end
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL reset_graphAvailable got %b exp 0", bus.graphAvailable); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.fifoCount !== 5'd0) begin n_fail++; $display("FAIL reset_fifoCount got %0d exp 0", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d exp 0", bus.outstanding); end
        n_checks++; if (bus.underflowError !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got %b exp 0", bus.underflowError); end
    endtask

    task automatic test_single();
        do_reset();
        bus.writeValid = 1'b1;
        bus.writeBot   = 128'h1;
        bus.writeExtra = EW'(5);
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", bus.graphAvailable); end
        tick();
        bus.writeValid = 1'b0;
        n_checks++; if (bus.graphAvailable !== 1'b1) begin n_fail++; $display("FAIL single_avail got %b exp 1", bus.graphAvailable); end
        n_checks++; if (bus.botOut !== 128'h1) begin n_fail++; $display("FAIL single_bot got %0h exp 1", bus.botOut); end
        n_checks++; if (bus.extraDataOut !== 14'd5) begin n_fail++; $display("FAIL single_tag got %0d exp 5", bus.extraDataOut); end
        bus.requestGraph = 1'b1;
        tick();
        bus.requestGraph = 1'b0;
        n_checks++; if (bus.fifoCount !== 5'd0) begin n_fail++; $display("FAIL single_count got %0d exp 0", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd1) begin n_fail++; $display("FAIL single_outst got %0d exp 1", bus.outstanding); end
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL single_avail_after got %b exp 0", bus.graphAvailable); end
        n_checks++; if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", bus.idle); end
        bus.resultDone = 1'b1;
        tick();
        bus.resultDone = 1'b0;
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_done got %b exp 1", bus.idle); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_write(1'b1, i);
            tick();
        end
        set_write(1'b1, 99);
        n_checks++; if (bus.writeReady !== 1'b0) begin n_fail++; $display("FAIL full_writeReady got %b exp 0", bus.writeReady); end
        n_checks++; if (bus.fifoCount !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d exp 16", bus.fifoCount); end
        tick();
        n_checks++; if (bus.fifoCount !== 5'd16) begin n_fail++; $display("FAIL full_17th_ignored got %0d exp 16", bus.fifoCount); end
        // Pop while full with a write offered: the write must not be taken.
        bus.requestGraph = 1'b1;
        tick();
        bus.requestGraph = 1'b0;
        set_write(1'b0, 0);
        n_checks++; if (bus.fifoCount !== 5'd15) begin n_fail++; $display("FAIL full_pop_write got %0d exp 15", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd1) begin n_fail++; $display("FAIL full_pop_outst got %0d exp 1", bus.outstanding); end
        set_write(1'b1, 16);
        tick();
        set_write(1'b0, 0);
        for (int i = 1; i <= 16; i++) begin
            n_checks++; if (bus.extraDataOut !== EW'(i)) begin n_fail++; $display("FAIL wrap_tag_%0d got %0d exp %0d", i, bus.extraDataOut, i); end
            n_checks++; if (bus.botOut !== 128'(i) + 128'd1000) begin n_fail++; $display("FAIL wrap_bot_%0d got %0d exp %0d", i, bus.botOut, i + 1000); end
            bus.requestGraph = 1'b1;
            tick();
        end
        bus.requestGraph = 1'b0;
        n_checks++; if (bus.fifoCount !== 5'd0) begin n_fail++; $display("FAIL wrap_empty got %0d exp 0", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd17) begin n_fail++; $display("FAIL wrap_outst got %0d exp 17", bus.outstanding); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_write(1'b1, i);
            tick();
        end
        bus.requestGraph = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_write(1'b1, 8 + i);
            n_checks++; if (bus.extraDataOut !== EW'(i)) begin n_fail++; $display("FAIL b2b_tag_%0d got %0d exp %0d", i, bus.extraDataOut, i); end
            n_checks++; if (bus.fifoCount !== 5'd8) begin n_fail++; $display("FAIL b2b_count_%0d got %0d exp 8", i, bus.fifoCount); end
            tick();
        end
        idle_inputs();
        n_checks++; if (bus.fifoCount !== 5'd8) begin n_fail++; $display("FAIL b2b_count_end got %0d exp 8", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd10) begin n_fail++; $display("FAIL b2b_outst got %0d exp 10", bus.outstanding); end
        n_checks++; if (bus.extraDataOut !== 14'd10) begin n_fail++; $display("FAIL b2b_head got %0d exp 10", bus.extraDataOut); end
    endtask

    task automatic test_ceiling();
        do_reset();
        bus.requestGraph = 1'b1;
        for (int i = 0; i < 70; i++) begin
            set_write(1'b1, i);
            tick();
        end
        set_write(1'b0, 0);
        tick();
        n_checks++; if (bus.outstanding !== 6'd63) begin n_fail++; $display("FAIL ceil_outst got %0d exp 63", bus.outstanding); end
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL ceil_avail got %b exp 0", bus.graphAvailable); end
        n_checks++; if (bus.fifoCount !== 5'd7) begin n_fail++; $display("FAIL ceil_count got %0d exp 7", bus.fifoCount); end
        n_checks++; if (bus.extraDataOut !== 14'd63) begin n_fail++; $display("FAIL ceil_head got %0d exp 63", bus.extraDataOut); end
        bus.resultDone = 1'b1;
        tick();
        bus.resultDone = 1'b0;
        n_checks++; if (bus.outstanding !== 6'd62) begin n_fail++; $display("FAIL ceil_done_outst got %0d exp 62", bus.outstanding); end
        n_checks++; if (bus.graphAvailable !== 1'b1) begin n_fail++; $display("FAIL ceil_done_avail got %b exp 1", bus.graphAvailable); end
        tick();
        n_checks++; if (bus.outstanding !== 6'd63) begin n_fail++; $display("FAIL ceil_reissue_outst got %0d exp 63", bus.outstanding); end
        n_checks++; if (bus.fifoCount !== 5'd6) begin n_fail++; $display("FAIL ceil_reissue_count got %0d exp 6", bus.fifoCount); end
        repeat (2) tick();
        n_checks++; if (bus.fifoCount !== 5'd6) begin n_fail++; $display("FAIL ceil_hold_count got %0d exp 6", bus.fifoCount); end
        idle_inputs();
    endtask

    task automatic test_done_underflow();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_write(1'b1, i);
            tick();
        end
        set_write(1'b0, 0);
        bus.requestGraph = 1'b1;
        tick();
        n_checks++; if (bus.outstanding !== 6'd1) begin n_fail++; $display("FAIL done_pop1 got %0d exp 1", bus.outstanding); end
        bus.resultDone = 1'b1;
        tick();
        bus.resultDone = 1'b0;
        n_checks++; if (bus.outstanding !== 6'd1) begin n_fail++; $display("FAIL done_pop_and_done got %0d exp 1", bus.outstanding); end
        tick();
        bus.requestGraph = 1'b0;
        n_checks++; if (bus.outstanding !== 6'd2) begin n_fail++; $display("FAIL done_pop3 got %0d exp 2", bus.outstanding); end
        bus.resultDone = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.outstanding !== 6'd0) begin n_fail++; $display("FAIL done_drain got %0d exp 0", bus.outstanding); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL done_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.underflowError !== 1'b0) begin n_fail++; $display("FAIL done_no_underflow got %b exp 0", bus.underflowError); end
        tick();
        bus.resultDone = 1'b0;
        n_checks++; if (bus.underflowError !== 1'b1) begin n_fail++; $display("FAIL underflow_set got %b exp 1", bus.underflowError); end
        n_checks++; if (bus.outstanding !== 6'd0) begin n_fail++; $display("FAIL underflow_outst got %0d exp 0", bus.outstanding); end
        tick();
        n_checks++; if (bus.underflowError !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b exp 1", bus.underflowError); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.resultDone = 1'b1;
        tick();
        bus.resultDone = 1'b0;
        for (int i = 0; i < 11; i++) begin
            set_write(1'b1, i);
            tick();
        end
        set_write(1'b0, 0);
        bus.requestGraph = 1'b1;
        repeat (4) tick();
        bus.requestGraph = 1'b0;
        n_checks++; if (bus.fifoCount !== 5'd7 || bus.outstanding !== 6'd4 || bus.underflowError !== 1'b1) begin
            n_fail++; $display("FAIL arst_setup got cnt=%0d out=%0d uf=%b exp cnt=7 out=4 uf=1", bus.fifoCount, bus.outstanding, bus.underflowError);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.fifoCount !== 5'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", bus.fifoCount); end
        n_checks++; if (bus.outstanding !== 6'd0) begin n_fail++; $display("FAIL arst_outst got %0d exp 0", bus.outstanding); end
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL arst_avail got %b exp 0", bus.graphAvailable); end
        n_checks++; if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL arst_idle got %b exp 1", bus.idle); end
        n_checks++; if (bus.underflowError !== 1'b0) begin n_fail++; $display("FAIL arst_underflow got %b exp 0", bus.underflowError); end
        tick();
        rst = 1'b0;
        set_write(1'b1, 42);
        n_checks++; if (bus.graphAvailable !== 1'b0) begin n_fail++; $display("FAIL arst_first_write_early got %b exp 0", bus.graphAvailable); end
        tick();
        set_write(1'b0, 0);
        n_checks++; if (bus.graphAvailable !== 1'b1) begin n_fail++; $display("FAIL arst_first_write_avail got %b exp 1", bus.graphAvailable); end
        n_checks++; if (bus.extraDataOut !== 14'd42) begin n_fail++; $display("FAIL arst_first_write_tag got %0d exp 42", bus.extraDataOut); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_full_wrap();
        test_back_to_back();
        test_ceiling();
        test_done_underflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
